// File: rtl/seg_scan_display.sv
// Multiplexed hex driver for common-anode 7-segment digits with a registered priority encoder.
// Latency: seg/dp_n/an are 1 cycle behind cnt/ptr/disp_q; enc_in reaches digit 0's segments in 2 cycles.
// No backpressure. Define SEG_LEADING_ZERO_BLANK_EN to blank digits above the highest nonzero nibble.
module seg_scan_display #(
  parameter int DIGITS = 4,
  parameter int ENC_W  = 8,
  parameter int DIV    = 1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ENC_W-1:0]           enc_in,
  input  logic                       load,
  input  logic [4*DIGITS-1:0]        value_in,
  input  logic                       show_enc,
  output logic [$clog2(ENC_W)-1:0]   enc_idx,
  output logic                       enc_valid,
  output logic [6:0]                 seg,
  output logic                       dp_n,
  output logic [DIGITS-1:0]          an
);

  localparam int IDX_W = $clog2(ENC_W);
  localparam int CNT_W = $clog2(DIV);
  localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [IDX_W-1:0]    enc_idx_q, enc_idx_d;
  logic                enc_valid_q, enc_valid_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                wrap;
  logic                enc_sel;
  logic [3:0]          nib_disp;
  logic [3:0]          nib_sel;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [PTR_W-1:0]    top_nz;
`endif

  // Active-low segment pattern, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    enc_idx_d = '0;
    for (int i = 0; i < ENC_W; i++) begin
      if (enc_in[i]) enc_idx_d = IDX_W'(i);
    end
    enc_valid_d = |enc_in;

    disp_d = load ? value_in : disp_q;

    wrap  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    ptr_d = ptr_q;
    if (wrap) ptr_d = (ptr_q == PTR_W'(DIGITS - 1)) ? '0 : ptr_q + 1'b1;

    nib_disp = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (ptr_q == PTR_W'(i)) nib_disp = disp_q[4*i +: 4];
    end

    enc_sel = show_enc && (ptr_q == '0);
    nib_sel = enc_sel ? 4'(enc_idx_q) : nib_disp;

    seg_d  = hex7(nib_sel);
    if (enc_sel && !enc_valid_q) seg_d = 7'b1111111;
    dp_n_d = !(enc_sel && enc_valid_q);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Digit 0 is never above top_nz, so an all-zero value still shows one "0".
    top_nz = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_q[4*i +: 4] != 4'h0) top_nz = PTR_W'(i);
    end
    if (ptr_q > top_nz) begin
      seg_d  = 7'b1111111;
      dp_n_d = 1'b1;
    end
`endif

    an_d = wrap ? '1 : ~(DIGITS'(1) << ptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ptr_q       <= '0;
      disp_q      <= '0;
      enc_idx_q   <= '0;
      enc_valid_q <= 1'b0;
      seg_q       <= 7'b1111111;
      dp_n_q      <= 1'b1;
      an_q        <= '1;
    end else begin
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      disp_q      <= disp_d;
      enc_idx_q   <= enc_idx_d;
      enc_valid_q <= enc_valid_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      an_q        <= an_d;
    end
  end

  assign enc_idx   = enc_idx_q;
  assign enc_valid = enc_valid_q;
  assign seg       = seg_q;
  assign dp_n      = dp_n_q;
  assign an        = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display at DIGITS=4, ENC_W=8, DIV=4.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  enc_in = '0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic        show_enc = 1'b0;
  logic [2:0]  enc_idx;
  logic        enc_valid;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b0000001;
`endif

  logic [3:0] an_tab [17] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                              4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};

  seg_scan_display #(.DIGITS(4), .ENC_W(8), .DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enc_in   (enc_in),
    .load     (load),
    .value_in (value_in),
    .show_enc (show_enc),
    .enc_idx  (enc_idx),
    .enc_valid(enc_valid),
    .seg      (seg),
    .dp_n     (dp_n),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait until the given digit-select pattern appears.
  task automatic wait_an(input logic [3:0] t);
    for (int i = 0; i < 40; i++) begin
      if (an === t) break;
      step();
    end
  endtask

  task automatic check_digits(input logic [15:0] v, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e [4];
    logic [3:0] t;
    e = '{e0, e1, e2, e3};
    value_in = v;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    for (int d = 0; d < 4; d++) begin
      t = 4'b0001 << d;
      t = ~t;
      wait_an(t);
      chk("digit_an", 32'(an), 32'(t));
      chk("digit_seg", 32'(seg), 32'(e[d]));
    end
  endtask

  initial begin
    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_seg", 32'(seg), 32'(BLANK));
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_dp", 32'(dp_n), 32'h1);
    chk("rst_idx", 32'(enc_idx), 32'h0);
    chk("rst_vld", 32'(enc_valid), 32'h0);
    step();
    step();
    chk("rst_hold_an", 32'(an), 32'hF);

    // First cycle after release: digit 0 shows "0", then the scan sequence
    rst_n = 1'b1;
    step();
    chk("first_an", 32'(an), 32'hE);
    chk("first_seg", 32'(seg), 32'b0000001);
    chk("first_dp", 32'(dp_n), 32'h1);
    for (int k = 1; k < 17; k++) begin
      step();
      chk("scan_an", 32'(an), 32'(an_tab[k]));
    end

    // Priority encoder and digit-0 encoder display
    enc_in = 8'b0010_1100;
    chk("enc_not_yet", 32'(enc_idx), 32'h0);
    step();
    chk("enc_idx5", 32'(enc_idx), 32'h5);
    chk("enc_vld5", 32'(enc_valid), 32'h1);
    show_enc = 1'b1;
    step();
    step();
    wait_an(4'hE);
    chk("enc_an0", 32'(an), 32'hE);
    chk("enc_seg5", 32'(seg), 32'b0100100);
    chk("enc_dp0", 32'(dp_n), 32'h0);
    wait_an(4'hD);
    chk("enc_dp1", 32'(dp_n), 32'h1);
    chk("enc_seg_d1", 32'(seg), 32'(LZ));
    enc_in = 8'h80;
    step();
    chk("enc_idx7", 32'(enc_idx), 32'h7);
    enc_in = 8'h01;
    step();
    chk("enc_idx0_one", 32'(enc_idx), 32'h0);
    chk("enc_vld_one", 32'(enc_valid), 32'h1);
    enc_in = 8'h00;
    step();
    chk("enc_idx_zero", 32'(enc_idx), 32'h0);
    chk("enc_vld_zero", 32'(enc_valid), 32'h0);
    step();
    wait_an(4'hE);
    chk("enc_blank_an", 32'(an), 32'hE);
    chk("enc_blank_seg", 32'(seg), 32'(BLANK));
    chk("enc_blank_dp", 32'(dp_n), 32'h1);
    show_enc = 1'b0;

    // Hex decode across all digits
    check_digits(16'hA9F0, 7'b0000001, 7'b0111000, 7'b0000100, 7'b0001000);
    check_digits(16'hEDCB, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000);
    check_digits(16'h8761, 7'b1001111, 7'b0100000, 7'b0001111, 7'b0000000);
    check_digits(16'h0042, 7'b0010010, 7'b1001100, LZ, LZ);

    // Load coincident with the slot wrap out of digit 1
    wait_an(4'hE);
    wait_an(4'hF);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wrap_pre_an", 32'(an), 32'hD);
    end
    value_in = 16'h0300;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("wrap_gap_an", 32'(an), 32'hF);
    step();
    chk("wrap_d2_an", 32'(an), 32'hB);
    chk("wrap_d2_seg", 32'(seg), 32'b0000110);
    step();
    step();
    chk("wrap_d2_hold", 32'(an), 32'hB);
    step();
    chk("wrap_gap2_an", 32'(an), 32'hF);
    step();
    chk("wrap_d3_an", 32'(an), 32'h7);
    chk("wrap_d3_seg", 32'(seg), 32'(LZ));

    // Asynchronous reset in the middle of digit 2's slot
    enc_in = 8'h80;
    show_enc = 1'b1;
    wait_an(4'hB);
    step();
    chk("mid_an", 32'(an), 32'hB);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", 32'(seg), 32'(BLANK));
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_dp", 32'(dp_n), 32'h1);
    chk("mid_rst_idx", 32'(enc_idx), 32'h0);
    chk("mid_rst_vld", 32'(enc_valid), 32'h0);
    enc_in = 8'h00;
    show_enc = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_an", 32'(an), 32'hE);
    chk("post_rst_seg", 32'(seg), 32'b0000001);
    step();
    chk("post_rst_an2", 32'(an), 32'hE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
